// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, digit
// limits and the preset saturation helper.
package timer_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_RUN   = RUN,
    S_PAUSE = PAUSE,
    S_DONE  = DONE
  } state_t;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] SEC_T_MAX = 4'd5;

  // Source selected when the digit chain is (re)loaded.
  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_PRESET = 2'd1,
    SRC_STORE  = 2'd2
  } load_src_t;

  // Clamp an out-of-range BCD digit to the largest legal value.
  function automatic logic [3:0] bcd_sat(input logic [3:0] value, input logic [3:0] max);
    return (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD down-counting digit. Wraps 0 -> MAX on a decrement and reports a
// borrow to the next more significant digit in that same cycle.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Next digit value: a load overrides a decrement.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec) begin
      digit_d = (digit_q == 4'd0) ? MAX : (digit_q - 4'd1);
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// MM..M:SS BCD countdown timer with a 1 Hz prescaler and an
// IDLE/RUN/PAUSE/DONE state machine.
// Optional build macro TIMER_AUTORELOAD_EN: on completion the count reloads
// from the preset store and the timer keeps running.
//
// Control inputs are plain levels sampled every clock; there is no
// handshake. Priority within one cycle is load, then stop, then start.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 2,
  parameter int TICK_DIV   = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic                    start,
  input  logic                    stop,
  input  logic [3:0]              preset_sec_u,
  input  logic [3:0]              preset_sec_t,
  input  logic [4*MIN_DIGITS-1:0] preset_min,
  output logic [3:0]              count_sec_u,
  output logic [3:0]              count_sec_t,
  output logic [4*MIN_DIGITS-1:0] count_min,
  output logic                    running,
  output logic                    paused,
  output logic                    zero,
  output logic                    done
);

  localparam int MW = 4 * MIN_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic [3:0]    store_su_q, store_su_d;
  logic [3:0]    store_st_q, store_st_d;
  logic [MW-1:0] store_min_q, store_min_d;

  logic [3:0]    sat_su, sat_st;
  logic [MW-1:0] sat_min;
  logic [3:0]    ld_su, ld_st;
  logic [MW-1:0] ld_min;

  logic          tick, is_one;
  logic          dig_load, store_load, dec;
  load_src_t     load_src;
  logic          b_su, b_st;
  logic [MIN_DIGITS:0] min_dec;
  logic          unused_top_borrow;

  // Saturate the preset digits before they reach the count or the store.
  always_comb begin
    sat_su  = bcd_sat(preset_sec_u, BCD_MAX);
    sat_st  = bcd_sat(preset_sec_t, SEC_T_MAX);
    sat_min = '0;
    for (int i = 0; i < MIN_DIGITS; i++) begin
      sat_min[4*i +: 4] = bcd_sat(preset_min[4*i +: 4], BCD_MAX);
    end
  end

  // Select what gets loaded into the digit chain.
  always_comb begin
    ld_su  = 4'd0;
    ld_st  = 4'd0;
    ld_min = '0;
    case (load_src)
      SRC_PRESET: begin
        ld_su  = sat_su;
        ld_st  = sat_st;
        ld_min = sat_min;
      end
      SRC_STORE: begin
        ld_su  = store_su_q;
        ld_st  = store_st_q;
        ld_min = store_min_q;
      end
      default: ;
    endcase
  end

  assign zero   = (count_sec_u == 4'd0) && (count_sec_t == 4'd0) && (count_min == '0);
  assign is_one = (count_sec_u == 4'd1) && (count_sec_t == 4'd0) && (count_min == '0);
  assign tick   = (state_q == S_RUN) && (presc_q == PRESC_LAST);

`ifdef TIMER_AUTORELOAD_EN
  logic store_zero;
  assign store_zero = (store_su_q == 4'd0) && (store_st_q == 4'd0) && (store_min_q == '0);
`endif

  // Next-state, prescaler and digit-chain control.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    dig_load   = 1'b0;
    store_load = 1'b0;
    load_src   = SRC_ZERO;
    dec        = 1'b0;
    if (load && (state_q != S_RUN)) begin
      state_d    = S_IDLE;
      dig_load   = 1'b1;
      store_load = 1'b1;
      load_src   = SRC_PRESET;
    end else if (stop && (state_q == S_RUN)) begin
      state_d = S_PAUSE;
    end else if (stop && (state_q == S_PAUSE)) begin
      state_d  = S_IDLE;
      dig_load = 1'b1;
      load_src = SRC_ZERO;
    end else if (start && !zero && ((state_q == S_IDLE) || (state_q == S_PAUSE))) begin
      state_d = S_RUN;
      presc_d = '0;
    end else if (state_q == S_RUN) begin
      presc_d = tick ? '0 : (presc_q + 1'b1);
      if (tick) begin
        if (is_one) begin
          done_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
          if (!store_zero) begin
            dig_load = 1'b1;
            load_src = SRC_STORE;
          end else begin
            dec     = 1'b1;
            state_d = S_DONE;
          end
`else
          dec     = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          dec = 1'b1;
        end
      end
    end
  end

  // Preset store follows accepted loads only.
  always_comb begin
    store_su_d  = store_su_q;
    store_st_d  = store_st_q;
    store_min_d = store_min_q;
    if (store_load) begin
      store_su_d  = sat_su;
      store_st_d  = sat_st;
      store_min_d = sat_min;
    end
  end

  // State, prescaler, done pulse and preset store registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      done_q      <= 1'b0;
      store_su_q  <= 4'd0;
      store_st_q  <= 4'd0;
      store_min_q <= '0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      done_q      <= done_d;
      store_su_q  <= store_su_d;
      store_st_q  <= store_st_d;
      store_min_q <= store_min_d;
    end
  end

  bcd_down_digit #(.MAX(BCD_MAX)) u_sec_u (
    .clk      (clk),
    .reset    (reset),
    .load     (dig_load),
    .load_val (ld_su),
    .dec      (dec),
    .digit    (count_sec_u),
    .borrow   (b_su)
  );

  bcd_down_digit #(.MAX(SEC_T_MAX)) u_sec_t (
    .clk      (clk),
    .reset    (reset),
    .load     (dig_load),
    .load_val (ld_st),
    .dec      (b_su),
    .digit    (count_sec_t),
    .borrow   (b_st)
  );

  assign min_dec[0] = b_st;

  for (genvar i = 0; i < MIN_DIGITS; i++) begin : g_min
    bcd_down_digit #(.MAX(BCD_MAX)) u_min (
      .clk      (clk),
      .reset    (reset),
      .load     (dig_load),
      .load_val (ld_min[4*i +: 4]),
      .dec      (min_dec[i]),
      .digit    (count_min[4*i +: 4]),
      .borrow   (min_dec[i+1])
    );
  end

  // The chain never decrements from zero, so the top borrow stays low.
  assign unused_top_borrow = min_dec[MIN_DIGITS];

  assign running = (state_q == S_RUN);
  assign paused  = (state_q == S_PAUSE);
  assign done    = done_q;

endmodule
